// File: rtl/tone_envelope_gen.sv
// tone_envelope_gen: note-indexed square-wave tone with linear attack/sustain/release envelope
module tone_envelope_gen #(
  parameter int ENV_MAX      = 255,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2,
  parameter int AMP_SHIFT    = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic        note_start,
  input  logic        note_stop,
  input  logic [4:0]  note,
  input  logic        octave_up,
  output logic [23:0] audio,
  output logic [7:0]  env_level,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
  // Half-period in sample ticks, round(24000/f); 0 marks a rest
  localparam logic [6:0] HP_ROM [32] = '{
    7'd0,  7'd92, 7'd87, 7'd82, 7'd77, 7'd73, 7'd69, 7'd65, 7'd61, 7'd58, 7'd55,
    7'd51, 7'd49, 7'd46, 7'd43, 7'd41, 7'd39, 7'd36, 7'd34, 7'd32, 7'd31, 7'd29,
    7'd27, 7'd26, 7'd24, 7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0
  };
  state_t      state;
  logic [6:0]  hp, hp_reg, half_cnt;
  logic        sq, rest_reg;
  logic [8:0]  env_up, env_dn;
  logic [23:0] mag;
  assign hp     = HP_ROM[note];
  assign env_up = {1'b0, env_level} + 9'(ATTACK_STEP);
  assign env_dn = {1'b0, env_level} - 9'(RELEASE_STEP);
  assign mag    = 24'(env_level) << AMP_SHIFT;
  assign audio  = (rest_reg || state == IDLE) ? 24'd0 : (sq ? mag : -mag);
  assign busy   = (state != IDLE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      env_level <= 8'd0;
      half_cnt  <= 7'd0;
      sq        <= 1'b1;
      hp_reg    <= 7'd0;
      rest_reg  <= 1'b1;
    end else if (note_start) begin
      hp_reg   <= octave_up ? hp >> 1 : hp;
      rest_reg <= (hp == 7'd0);
      half_cnt <= 7'd0;
      sq       <= 1'b1;
      state    <= ATTACK;
    end else begin
      if (note_stop && (state == ATTACK || state == SUSTAIN))
        state <= RELEASE;
      else if (sample_tick)
        case (state)
          IDLE:    env_level <= 8'd0;
          ATTACK:
            if (env_up >= 9'(ENV_MAX)) begin
              env_level <= 8'(ENV_MAX);
              state     <= SUSTAIN;
            end else
              env_level <= env_up[7:0];
          SUSTAIN: env_level <= 8'(ENV_MAX);
          RELEASE:
            if (env_dn[8] || env_dn == 9'd0) begin
              env_level <= 8'd0;
              state     <= IDLE;
            end else
              env_level <= env_dn[7:0];
          default: state <= IDLE;
        endcase
      if (sample_tick && !rest_reg && state != IDLE) begin
        if (half_cnt == hp_reg - 7'd1) begin
          sq       <= ~sq;
          half_cnt <= 7'd0;
        end else
          half_cnt <= half_cnt + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_tone_envelope_gen.sv
// tb_tone_envelope_gen: scoreboard and table-driven checks for tone_envelope_gen
module tb_tone_envelope_gen;
  logic        clk = 0, reset_n = 0, sample_tick = 0, note_start = 0, note_stop = 0, octave_up = 0;
  logic [4:0]  note = 0;
  logic [23:0] audio;
  logic [7:0]  env_level;
  logic        busy;
  int tests = 0, fails = 0;

  tone_envelope_gen dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .note_start(note_start),
    .note_stop(note_stop), .note(note), .octave_up(octave_up),
    .audio(audio), .env_level(env_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  env;
    logic [23:0] aud;
    logic        bz;
    string       tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] n;
    logic       oc;
    int         hp;
  } vec_t;

  function automatic exp_t mk(string tag, int env, bit neg, bit silent, bit bz);
    exp_t e;
    logic [23:0] m;
    m = 24'(env) << 12;
    e.env = 8'(env);
    e.aud = silent ? 24'd0 : (neg ? -m : m);
    e.bz  = bz;
    e.tag = tag;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic pop_check;
    exp_t e;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_underflow got=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, "_env"}, 32'(env_level), 32'(e.env));
      cmp({e.tag, "_audio"}, 32'(audio), 32'(e.aud));
      cmp({e.tag, "_busy"}, 32'(busy), 32'(e.bz));
    end
  endtask

  task automatic step(input logic tk, input logic ns, input logic np, input exp_t e);
    sb.push_back(e);
    sample_tick = tk; note_start = ns; note_stop = np;
    @(negedge clk);
    sample_tick = 0; note_start = 0; note_stop = 0;
    pop_check();
  endtask

  task automatic tick_raw;
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
  endtask

  function automatic int env_atk(int t);
    return (8 * t > 255) ? 255 : 8 * t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t vec [10];
    int env, t, c;
    bit found, silent, bz_ok;
    vec[0] = '{5'd1, 1'b0, 92};
    vec[1] = '{5'd10, 1'b0, 55};
    vec[2] = '{5'd13, 1'b0, 46};
    vec[3] = '{5'd22, 1'b0, 27};
    vec[4] = '{5'd24, 1'b0, 24};
    vec[5] = '{5'd10, 1'b1, 27};
    vec[6] = '{5'd24, 1'b1, 12};
    vec[7] = '{5'd5, 1'b1, 36};
    vec[8] = '{5'd0, 1'b0, 0};
    vec[9] = '{5'd30, 1'b0, 0};

    repeat (2) @(negedge clk);
    sb.push_back(mk("reset", 0, 0, 1, 0));
    pop_check();
    reset_n = 1;
    step(1, 0, 0, mk("idle_tick", 0, 0, 1, 0));

    // Attack into sustain with ticks every 4 clocks; registers hold between ticks
    note = 5'd10; octave_up = 0;
    step(0, 1, 0, mk("start", 0, 0, 1, 1));
    for (int k = 1; k <= 60; k++) begin
      step(1, 0, 0, mk("attack", env_atk(k), k >= 55, 0, 1));
      if (k == 40) cmp("audio_t40", 32'(audio), 32'h0FF000);
      repeat (3) step(0, 0, 0, mk("hold", env_atk(k), k >= 55, 0, 1));
    end
    cmp("audio_t60", 32'(audio), 32'hF01000);

    // Release from sustain down to idle
    step(0, 0, 1, mk("stop", 255, 1, 0, 1));
    for (int k = 1; k <= 128; k++) begin
      t = 60 + k;
      env = 255 - 2 * k;
      if (env < 0) env = 0;
      step(1, 0, 0, mk("release", env, ((t / 55) % 2) == 1, k == 128, k != 128));
      if (k == 127) cmp("release_env_127", 32'(env_level), 32'd1);
    end
    repeat (5) step(1, 0, 0, mk("post_release", 0, 0, 1, 0));

    // Asynchronous reset mid-sustain
    step(0, 1, 0, mk("start2", 0, 0, 1, 1));
    for (int k = 1; k <= 40; k++) step(1, 0, 0, mk("attack2", env_atk(k), 0, 0, 1));
    #2 reset_n = 0;
    #1;
    cmp("async_audio", 32'(audio), 32'd0);
    cmp("async_env", 32'(env_level), 32'd0);
    cmp("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1;
    repeat (5) step(1, 0, 0, mk("post_reset", 0, 0, 1, 0));

    // Start+stop+tick collision during release at env=100
    step(0, 1, 0, mk("start3", 0, 0, 1, 1));
    for (int k = 1; k <= 13; k++) step(1, 0, 0, mk("attack3", 8 * k, 0, 0, 1));
    step(0, 0, 1, mk("stop3", 104, 0, 0, 1));
    step(1, 0, 0, mk("release3", 102, 0, 0, 1));
    step(1, 0, 0, mk("release3", 100, 0, 0, 1));
    step(1, 1, 1, mk("collide", 100, 0, 0, 1));
    step(1, 0, 0, mk("collide_next", 108, 0, 0, 1));
    c = 200; found = 0;
    for (int i = 1; i <= 150; i++) begin
      tick_raw();
      if (!found && audio[23]) begin found = 1; c = i; end
    end
    cmp("collide_phase", 32'(c + 1), 32'd55);

    // Pitch table: ticks from note_start to the first negative half-cycle
    foreach (vec[i]) begin
      note = vec[i].n; octave_up = vec[i].oc;
      note_start = 1;
      @(negedge clk);
      note_start = 0;
      c = 0; found = 0; silent = 1; bz_ok = 1;
      for (int k = 1; k <= 120; k++) begin
        tick_raw();
        if (!found && audio[23]) begin found = 1; c = k; end
        if (audio != 24'd0) silent = 0;
        if (!busy) bz_ok = 0;
      end
      if (vec[i].hp == 0) begin
        cmp($sformatf("rest_silent_n%0d", vec[i].n), 32'(silent), 32'd1);
        cmp($sformatf("rest_env_n%0d", vec[i].n), 32'(env_level), 32'd255);
      end else
        cmp($sformatf("halfper_n%0d_o%0d", vec[i].n, vec[i].oc), 32'(c), 32'(vec[i].hp));
      cmp($sformatf("busy_n%0d", vec[i].n), 32'(bz_ok), 32'd1);
    end

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tone_envelope_gen.md
Name: tone_envelope_gen

Overview:
- Sample-rate tone source feeding the codec write path.
- On each codec write strobe it produces one signed 24-bit square-wave sample. The sample is shaped by a linear attack/sustain/release envelope.
- Pitch is a 5-bit note index from the score/keyboard path, with an optional octave-up.
- Sits directly upstream of the writedata_left/right mux; replaces the flat-amplitude output so note edges do not click.

Parameters:
- ENV_MAX, 255, sustain envelope level (8-bit, 1..255).
- ATTACK_STEP, 8, envelope increment per sample tick in ATTACK.
- RELEASE_STEP, 2, envelope decrement per sample tick in RELEASE.
- AMP_SHIFT, 12, left shift applied to the envelope to form sample magnitude.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe, one per codec sample (tied to write).
- note_start  in  1  one-cycle pulse; latch note/octave_up and (re)trigger.
- note_stop  in  1  one-cycle pulse; begin release.
- note  in  5  note index: 0 = rest, 1..24 = C4..B5 chromatic, 25..31 = rest.
- octave_up  in  1  when latched high, half-period is halved.
- audio  out  24  signed sample.
- env_level  out  8  current envelope level.
- busy  out  1  high in ATTACK, SUSTAIN or RELEASE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, env_level=0, half_cnt=0, sq=1, hp_reg=0, rest_reg=1.
  - audio=0, busy=0.
- Half-period ROM, combinational on note:
  - hp = round(24000 / f), with f = 440 * 2^((n-10)/12).
  - Required entries: n=1 gives 92, n=10 gives 55, n=13 gives 46, n=22 gives 27, n=24 gives 24.
  - Rest indices give hp=0.
- note_start at any clock edge, in any state, regardless of sample_tick:
  - hp_reg = octave_up ? hp>>1 : hp.
  - rest_reg = (hp==0); half_cnt=0; sq=1; state=ATTACK.
  - env_level is retained, with no reset to 0, to avoid a click.
- note_stop (without note_start) in ATTACK or SUSTAIN: state=RELEASE, env unchanged. It is ignored in IDLE and RELEASE.
- note_start and note_stop in the same cycle: note_start wins.
- Everything below advances only on edges where sample_tick=1. Between ticks, all registers hold.
- Phase:
  - If half_cnt == hp_reg-1: sq toggles and half_cnt=0; otherwise half_cnt+1.
  - The phase is frozen when rest_reg=1 or state=IDLE.
  - One full period is 2*hp_reg ticks.
- Envelope FSM:
  - IDLE: env=0, stays until note_start.
  - ATTACK: env = min(env+ATTACK_STEP, ENV_MAX). When the result == ENV_MAX, go to SUSTAIN on the same edge.
  - SUSTAIN: env=ENV_MAX, stays until note_stop or note_start.
  - RELEASE: env = max(env-RELEASE_STEP, 0). When the result == 0, go to IDLE on the same edge.
  - Saturation arithmetic is done 9-bit wide with no wrap-around.
- If note_start and sample_tick coincide, the note_start load takes priority; no envelope/phase step occurs that cycle.
- audio, combinational from registers and valid from the updating edge:
  - 0 if rest_reg or state=IDLE.
  - Otherwise sign-extended +(env_level<<AMP_SHIFT) when sq=1, and its two's complement when sq=0.
  - Maximum magnitude is 255<<12 = 0x0FF000, which never overflows 24-bit signed.
- busy = (state != IDLE).
- Reset asserted mid-note forces IDLE and audio=0 immediately (asynchronous), without waiting for a tick.

Test Plan:
- Reset with reset_n=0 mid-SUSTAIN -> audio=0, env_level=0, busy=0 within the same cycle; after release nothing changes until note_start.
- note=10, octave_up=0, note_start, then ticks every 4 clocks -> env: 8,16,...,248,255 (SUSTAIN on tick 32); sq toggles every 55 ticks; at tick 40 audio=0x0FF000, at tick 60 audio=0xF01000.
- Same note with octave_up=1 -> hp_reg=27, sq toggles every 27 ticks.
- In SUSTAIN, note_stop -> env falls by 2 per tick, reaches 1 after 127 ticks and 0 after 128 ticks; state=IDLE and busy=0 on that edge.
- note=0 or note=30 with note_start -> busy=1 and env ramps, but audio stays 0 throughout.
- During RELEASE at env=100, note_start and note_stop in the same cycle together with sample_tick -> state=ATTACK, env stays 100 that cycle and reaches 108 on the next tick, half_cnt=0, sq=1.
